sys_bus_ctrl: RTL and testbench

Single-master data-bus controller between the core's load/store port and the memory segments (SFR, IO, DFM, PFM). It consumes the one-hot segment enables produced by the address map decoder for the current request address. It registers the request, drives exactly one target with a select strobe and waits for that target's ready. It then returns read data, or an error, to the core as a one-cycle response. Undefined-region accesses, PFM writes and (optionally) hung targets are terminated with `rsp_err`.

---
 rtl/sys_bus_pkg.sv | 33 +++
 rtl/bus_timeout_cnt.sv | 37 +++
 rtl/sys_bus_ctrl.sv | 154 +++++++++++++++
 tb/tb_sys_bus_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_bus_pkg.sv
// sys_bus_pkg
// Shared types and constants for the system data-bus controller.
//   bus_state_t : controller FSM states (IDLE, ACCESS, RESP)
//   TGT_*       : bit positions of each target in tgt_sel / tgt_ready
//   BUS_TO_W    : width of the optional access timeout counter
//   oh_to_idx   : one-hot target enable vector -> target index
package sys_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } bus_state_t;

  localparam int TGT_SFR  = 0;
  localparam int TGT_IO   = 1;
  localparam int TGT_DFM  = 2;
  localparam int TGT_PFM  = 3;
  localparam int TGT_NUM  = 4;
  localparam int BUS_TO_W = 16;

  // Only meaningful for a one-hot input; any other pattern is rejected
  // upstream before the index is ever used to strobe a target.
  function automatic logic [1:0] oh_to_idx(input logic [TGT_NUM-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    if (oh[TGT_IO])  idx = 2'(TGT_IO);
    if (oh[TGT_DFM]) idx = 2'(TGT_DFM);
    if (oh[TGT_PFM]) idx = 2'(TGT_PFM);
    return idx;
  endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// bus_timeout_cnt
// Counts ACCESS cycles without target ready and flags the cycle in which
// the count would reach LIMIT. Only instantiated when SYS_BUS_TIMEOUT_EN
// is defined.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   clr    : clear the count (held while not in ACCESS)
//   en     : count this cycle (ACCESS without selected ready)
//   expire : this waiting cycle is the LIMIT-th one; abort the access
module bus_timeout_cnt
  import sys_bus_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [BUS_TO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fire one cycle early so the FSM leaves ACCESS on the edge where the
  // count reaches LIMIT; LIMIT waiting cycles are seen with tgt_sel high.
  assign expire = en && (cnt == BUS_TO_W'(LIMIT - 1));

endmodule

// File: rtl/sys_bus_ctrl.sv
// sys_bus_ctrl
// Single-master data-bus controller between the core load/store port and
// the SFR / IO / DFM / PFM memory segments. One outstanding access; the
// request is registered, exactly one target is strobed until its ready,
// and a one-cycle response (data or error) is returned to the core.
// Optional feature macro: SYS_BUS_TIMEOUT_EN (abort hung targets after
// TIMEOUT_CYCLES waiting cycles with rsp_err).
// Ports:
//   sys_clk, sys_rst_n        : clock, synchronous active-low reset
//   req_*                     : core request (valid/ready handshake)
//   en_mem_*                  : combinational segment decode of req_addr
//   tgt_sel, tgt_we/be/addr/wdata : one-hot strobe and shared request copy
//   tgt_ready, tgt_rdata_*    : per-target completion and read data
//   rsp_valid, rsp_rdata, rsp_err : one-cycle response to the core
module sys_bus_ctrl
  import sys_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [3:0]          req_be,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  input  logic                en_mem_sfr,
  input  logic                en_mem_io,
  input  logic                en_mem_undef,
  input  logic                en_mem_dfm,
  input  logic                en_mem_pfm,
  output logic [TGT_NUM-1:0]  tgt_sel,
  output logic                tgt_we,
  output logic [3:0]          tgt_be,
  output logic [31:0]         tgt_addr,
  output logic [31:0]         tgt_wdata,
  input  logic [TGT_NUM-1:0]  tgt_ready,
  input  logic [31:0]         tgt_rdata_sfr,
  input  logic [31:0]         tgt_rdata_io,
  input  logic [31:0]         tgt_rdata_dfm,
  input  logic [31:0]         tgt_rdata_pfm,
  output logic                rsp_valid,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_err
);

  bus_state_t          state, state_nxt;
  logic [1:0]          tgt_idx;
  logic [TGT_NUM-1:0]  real_en;
  logic                real_onehot;
  logic                req_bad;
  logic                sel_ready;
  logic                timeout;
  logic                acc_done;
  logic [31:0]         rdata_mux;

  // Request classification: undefined region, ambiguous/missing decode
  // and writes into program flash never reach a target.
  always_comb begin
    real_en                = '0;
    real_en[TGT_SFR]       = en_mem_sfr;
    real_en[TGT_IO]        = en_mem_io;
    real_en[TGT_DFM]       = en_mem_dfm;
    real_en[TGT_PFM]       = en_mem_pfm;
    real_onehot            = (real_en != '0) && ((real_en & (real_en - 1'b1)) == '0);
    req_bad                = en_mem_undef || !real_onehot || (req_we && en_mem_pfm);
  end

  // Completion and read data are taken only from the latched target.
  always_comb begin
    sel_ready = tgt_ready[tgt_idx];
    unique case (tgt_idx)
      2'(TGT_SFR): rdata_mux = tgt_rdata_sfr;
      2'(TGT_IO):  rdata_mux = tgt_rdata_io;
      2'(TGT_DFM): rdata_mux = tgt_rdata_dfm;
      default:     rdata_mux = tgt_rdata_pfm;
    endcase
  end

`ifdef SYS_BUS_TIMEOUT_EN
  bus_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .clr    (state != ACCESS),
    .en     ((state == ACCESS) && !sel_ready),
    .expire (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Ready has priority: timeout only asserts when ready is absent.
  assign acc_done = (state == ACCESS) && (sel_ready || timeout);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    tgt_sel   = '0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_bad ? RESP : ACCESS;
      end
      ACCESS: begin
        tgt_sel = TGT_NUM'(1) << tgt_idx;
        if (acc_done) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request copy, target index and response registers. rsp_err is decided
  // on acceptance for decode faults and on completion for timeouts, and
  // both response registers return to 0 once the response has been shown.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      tgt_we    <= 1'b0;
      tgt_be    <= '0;
      tgt_addr  <= '0;
      tgt_wdata <= '0;
      tgt_idx   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if ((state == IDLE) && req_valid) begin
      tgt_we    <= req_we;
      tgt_be    <= req_be;
      tgt_addr  <= req_addr;
      tgt_wdata <= req_wdata;
      tgt_idx   <= oh_to_idx(real_en);
      rsp_rdata <= '0;
      rsp_err   <= req_bad;
    end else if (acc_done) begin
      rsp_rdata <= (sel_ready && !tgt_we) ? rdata_mux : '0;
      rsp_err   <= !sel_ready;
    end else if (state == RESP) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sys_bus_ctrl.sv
// tb_sys_bus_ctrl
// Directed bench for sys_bus_ctrl. Inputs change 1 ns after the rising
// edge and outputs are compared at that same point, away from the edge.
// Timeout scenarios are built only when SYS_BUS_TIMEOUT_EN is defined.
module tb_sys_bus_ctrl;

  localparam int TO = 8;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        en_mem_sfr, en_mem_io, en_mem_undef, en_mem_dfm, en_mem_pfm;
  logic [3:0]  tgt_sel;
  logic        tgt_we;
  logic [3:0]  tgt_be;
  logic [31:0] tgt_addr;
  logic [31:0] tgt_wdata;
  logic [3:0]  tgt_ready;
  logic [31:0] tgt_rdata_sfr, tgt_rdata_io, tgt_rdata_dfm, tgt_rdata_pfm;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;

  sys_bus_ctrl #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_be        (req_be),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .en_mem_sfr    (en_mem_sfr),
    .en_mem_io     (en_mem_io),
    .en_mem_undef  (en_mem_undef),
    .en_mem_dfm    (en_mem_dfm),
    .en_mem_pfm    (en_mem_pfm),
    .tgt_sel       (tgt_sel),
    .tgt_we        (tgt_we),
    .tgt_be        (tgt_be),
    .tgt_addr      (tgt_addr),
    .tgt_wdata     (tgt_wdata),
    .tgt_ready     (tgt_ready),
    .tgt_rdata_sfr (tgt_rdata_sfr),
    .tgt_rdata_io  (tgt_rdata_io),
    .tgt_rdata_dfm (tgt_rdata_dfm),
    .tgt_rdata_pfm (tgt_rdata_pfm),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  // e = {undef, pfm, dfm, io, sfr}
  task automatic set_en(input logic [4:0] e);
    {en_mem_undef, en_mem_pfm, en_mem_dfm, en_mem_io, en_mem_sfr} = e;
  endtask

  // Present a request for one edge, then clear all request inputs so later
  // checks see the registered copy, not the live bus.
  task automatic issue(input string tag, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] e);
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_be    = be;
    req_addr  = addr;
    req_wdata = wdata;
    set_en(e);
    cyc();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_be    = '0;
    req_addr  = '0;
    req_wdata = '0;
    set_en(5'b00000);
  endtask

  // Called in the cycle after acceptance of a faulting request.
  task automatic expect_err_rsp(input string tag);
    check({tag, " sel"},   32'(tgt_sel),   32'h0);
    check({tag, " valid"}, 32'(rsp_valid), 32'd1);
    check({tag, " err"},   32'(rsp_err),   32'd1);
    check({tag, " rdata"}, rsp_rdata,      32'h0);
    cyc();
    check({tag, " sel2"},  32'(tgt_sel),   32'h0);
    check({tag, " done"},  32'(rsp_valid), 32'd0);
    check({tag, " rdy2"},  32'(req_ready), 32'd1);
  endtask

  initial begin
    sys_rst_n     = 1'b0;
    req_valid     = 1'b0;
    req_we        = 1'b0;
    req_be        = '0;
    req_addr      = '0;
    req_wdata     = '0;
    set_en(5'b00000);
    tgt_ready     = '0;
    tgt_rdata_sfr = 32'h0;
    tgt_rdata_io  = 32'h0;
    tgt_rdata_dfm = 32'h0;
    tgt_rdata_pfm = 32'h0;
    cyc();
    cyc();

    // Reset state
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst tgt_sel",   32'(tgt_sel),   32'h0);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_err",   32'(rsp_err),   32'd0);
    check("rst rsp_rdata", rsp_rdata,      32'h0);
    check("rst tgt_addr",  tgt_addr,       32'h0);
    check("rst tgt_we",    32'(tgt_we),    32'd0);
    sys_rst_n = 1'b1;
    cyc();

    // DFM read, ready in first ACCESS cycle: response 2 cycles after accept
    issue("dfm", 1'b0, 4'hF, 32'h2000_0010, 32'h0, 5'b00100);
    check("dfm sel",   32'(tgt_sel),   32'h4);
    check("dfm rdy",   32'(req_ready), 32'd0);
    check("dfm vld0",  32'(rsp_valid), 32'd0);
    check("dfm addr",  tgt_addr,       32'h2000_0010);
    check("dfm we",    32'(tgt_we),    32'd0);
    tgt_ready     = 4'b0100;
    tgt_rdata_dfm = 32'hDEAD_BEEF;
    cyc();
    tgt_ready = '0;
    check("dfm vld",   32'(rsp_valid), 32'd1);
    check("dfm rdata", rsp_rdata,      32'hDEAD_BEEF);
    check("dfm err",   32'(rsp_err),   32'd0);
    check("dfm sel2",  32'(tgt_sel),   32'h0);
    cyc();
    check("dfm vld2",  32'(rsp_valid), 32'd0);
    check("dfm rdy2",  32'(req_ready), 32'd1);

    // SFR write, 3 wait cycles with unselected readies asserted
    tgt_rdata_sfr = 32'h55AA_55AA;
    issue("sfrw", 1'b1, 4'b0011, 32'h0000_0F04, 32'hCAFE_0123, 5'b00001);
    check("sfrw we",    32'(tgt_we),  32'd1);
    check("sfrw be",    32'(tgt_be),  32'h3);
    check("sfrw wdata", tgt_wdata,    32'hCAFE_0123);
    check("sfrw addr",  tgt_addr,     32'h0000_0F04);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sfrw sel%0d", i), 32'(tgt_sel),   32'h1);
      check($sformatf("sfrw vld%0d", i), 32'(rsp_valid), 32'd0);
      tgt_ready = (i == 3) ? 4'b0001 : 4'b1110;
      cyc();
    end
    tgt_ready = '0;
    check("sfrw vld",   32'(rsp_valid), 32'd1);
    check("sfrw rdata", rsp_rdata,      32'h0);
    check("sfrw err",   32'(rsp_err),   32'd0);
    cyc();

    // Decode faults: undefined region, two enables, no enable
    issue("undef", 1'b0, 4'hF, 32'h9000_0000, 32'h0, 5'b10000);
    expect_err_rsp("undef");
    issue("multi", 1'b0, 4'hF, 32'h1000_0000, 32'h0, 5'b00110);
    expect_err_rsp("multi");
    issue("none", 1'b0, 4'hF, 32'h1000_0000, 32'h0, 5'b00000);
    expect_err_rsp("none");

    // PFM write faults; PFM read of same address completes
    issue("pfmw", 1'b1, 4'hF, 32'h0000_0100, 32'h1111_2222, 5'b01000);
    expect_err_rsp("pfmw");
    issue("pfmr", 1'b0, 4'hF, 32'h0000_0100, 32'h0, 5'b01000);
    check("pfmr sel", 32'(tgt_sel), 32'h8);
    tgt_ready     = 4'b1000;
    tgt_rdata_pfm = 32'h0BAD_F00D;
    cyc();
    tgt_ready = '0;
    check("pfmr vld",   32'(rsp_valid), 32'd1);
    check("pfmr rdata", rsp_rdata,      32'h0BAD_F00D);
    check("pfmr err",   32'(rsp_err),   32'd0);
    cyc();

`ifdef SYS_BUS_TIMEOUT_EN
    // IO never ready: 8 strobe cycles, then error response
    issue("to", 1'b0, 4'hF, 32'h4000_0000, 32'h0, 5'b00010);
    for (int i = 0; i < TO; i++) begin
      check($sformatf("to sel%0d", i), 32'(tgt_sel),   32'h2);
      check($sformatf("to vld%0d", i), 32'(rsp_valid), 32'd0);
      cyc();
    end
    check("to sel_off", 32'(tgt_sel),   32'h0);
    check("to vld",     32'(rsp_valid), 32'd1);
    check("to err",     32'(rsp_err),   32'd1);
    check("to rdata",   rsp_rdata,      32'h0);
    cyc();
    // Ready in the 8th cycle wins over the timeout
    tgt_rdata_io = 32'h1234_5678;
    issue("tor", 1'b0, 4'hF, 32'h4000_0004, 32'h0, 5'b00010);
    for (int i = 0; i < TO; i++) begin
      check($sformatf("tor sel%0d", i), 32'(tgt_sel), 32'h2);
      tgt_ready = (i == TO - 1) ? 4'b0010 : 4'b0000;
      cyc();
    end
    tgt_ready = '0;
    check("tor vld",   32'(rsp_valid), 32'd1);
    check("tor err",   32'(rsp_err),   32'd0);
    check("tor rdata", rsp_rdata,      32'h1234_5678);
    cyc();
`else
    // Without the timeout, a long wait still completes without error
    tgt_rdata_io = 32'h1234_5678;
    issue("iow", 1'b0, 4'hF, 32'h4000_0004, 32'h0, 5'b00010);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("iow sel%0d", i), 32'(tgt_sel),   32'h2);
      check($sformatf("iow vld%0d", i), 32'(rsp_valid), 32'd0);
      tgt_ready = (i == 19) ? 4'b0010 : 4'b0000;
      cyc();
    end
    tgt_ready = '0;
    check("iow vld",   32'(rsp_valid), 32'd1);
    check("iow err",   32'(rsp_err),   32'd0);
    check("iow rdata", rsp_rdata,      32'h1234_5678);
    cyc();
`endif

    // Reset during ACCESS abandons the access
    issue("mrst", 1'b0, 4'hF, 32'h2000_0020, 32'h0, 5'b00100);
    check("mrst sel", 32'(tgt_sel), 32'h4);
    sys_rst_n = 1'b0;
    cyc();
    check("mrst sel0", 32'(tgt_sel),   32'h0);
    check("mrst rdy",  32'(req_ready), 32'd1);
    check("mrst vld",  32'(rsp_valid), 32'd0);
    check("mrst addr", tgt_addr,       32'h0);
    sys_rst_n = 1'b1;
    tgt_ready = 4'b0100;
    cyc();
    tgt_ready = '0;
    check("mrst vld2", 32'(rsp_valid), 32'd0);
    check("mrst sel2", 32'(tgt_sel),   32'h0);

    // Following read completes normally
    tgt_rdata_sfr = 32'hA5A5_0F0F;
    issue("post", 1'b0, 4'hF, 32'h0000_0F00, 32'h0, 5'b00001);
    check("post sel", 32'(tgt_sel), 32'h1);
    tgt_ready = 4'b0001;
    cyc();
    tgt_ready = '0;
    check("post vld",   32'(rsp_valid), 32'd1);
    check("post rdata", rsp_rdata,      32'hA5A5_0F0F);
    check("post err",   32'(rsp_err),   32'd0);
    cyc();
    check("post idle",  32'(rsp_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
